// File: rtl/ddr4_cmd_scheduler.sv
// ddr4_cmd_scheduler
//   Turns one in-order stream of read/write requests into DDR4 ACT/PRE/RD/WR
//   commands. Pages stay open after each access. The block remembers the open
//   row of each of the 16 banks. It holds each command until tRCD, tRP, tRAS,
//   tRRD_S/L and tCCD_S/L are satisfied. At most one command goes out per clock.
//
// Ports
//   clock_t    rising-edge clock
//   reset_n    asynchronous active-low reset
//   req_valid  host request present
//   req_ready  scheduler can take a request (high only while idle)
//   req_write  1 = write, 0 = read
//   req_bg     request bank group
//   req_ba     request bank
//   req_row    request row
//   req_col    request column
//   cmd_valid  a command is issued this cycle
//   cmd_type   0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
//   cmd_bg     command bank group
//   cmd_ba     command bank
//   cmd_addr   row for ACT, zero-extended column for RD/WR, 0 otherwise
module ddr4_cmd_scheduler #(
  parameter int BG_W    = 2,
  parameter int BA_W    = 2,
  parameter int ROW_W   = 17,
  parameter int COL_W   = 10,
  parameter int T_RCD   = 16,
  parameter int T_RP    = 16,
  parameter int T_RAS   = 39,
  parameter int T_RRD_S = 4,
  parameter int T_RRD_L = 6,
  parameter int T_CCD_S = 4,
  parameter int T_CCD_L = 6
) (
  input  logic             clock_t,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [BG_W-1:0]  req_bg,
  input  logic [BA_W-1:0]  req_ba,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             cmd_valid,
  output logic [2:0]       cmd_type,
  output logic [BG_W-1:0]  cmd_bg,
  output logic [BA_W-1:0]  cmd_ba,
  output logic [ROW_W-1:0] cmd_addr
);

  localparam int IDX_W     = BG_W + BA_W;
  localparam int NUM_BANKS = 1 << IDX_W;
  localparam int CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, SCHED} state_t;
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_t;

  state_t state_q, state_d;
  cmd_t   issue;
  logic [ROW_W-1:0] addr_d;

  logic             lat_write;
  logic [BG_W-1:0]  lat_bg;
  logic [BA_W-1:0]  lat_ba;
  logic [ROW_W-1:0] lat_row;
  logic [COL_W-1:0] lat_col;

  logic [NUM_BANKS-1:0] bank_open;
  logic [ROW_W-1:0]     bank_row  [NUM_BANKS];
  logic [CNT_W-1:0]     since_act [NUM_BANKS];
  logic [CNT_W-1:0]     since_pre [NUM_BANKS];
  logic [CNT_W-1:0]     last_act_cnt, last_cas_cnt;
  logic [BG_W-1:0]      last_act_bg, last_cas_bg;

  logic [IDX_W-1:0] idx;
  logic             accept, row_hit;
  logic             rcd_ok, ras_ok, rp_ok, rrd_ok, ccd_ok;
  logic [CNT_W-1:0] rrd_need, ccd_need;

  // A counter value c means "the last command happened c edges ago",
  // so a constraint T is met for the coming edge once c >= T.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign idx      = {lat_bg, lat_ba};
  assign accept   = req_valid & req_ready;
  assign row_hit  = bank_open[idx] && (bank_row[idx] == lat_row);
  assign rrd_need = (lat_bg == last_act_bg) ? CNT_W'(T_RRD_L) : CNT_W'(T_RRD_S);
  assign ccd_need = (lat_bg == last_cas_bg) ? CNT_W'(T_CCD_L) : CNT_W'(T_CCD_S);
  assign rcd_ok   = since_act[idx] >= CNT_W'(T_RCD);
  assign ras_ok   = since_act[idx] >= CNT_W'(T_RAS);
  assign rp_ok    = since_pre[idx] >= CNT_W'(T_RP);
  assign rrd_ok   = last_act_cnt >= rrd_need;
  assign ccd_ok   = last_cas_cnt >= ccd_need;

  // Next state and command choice for the latched request.
  always_comb begin
    state_d = state_q;
    issue   = CMD_NOP;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SCHED;
      end
      SCHED: begin
        if (bank_open[idx]) begin
          if (row_hit) begin
            if (rcd_ok && ccd_ok) begin
              issue   = lat_write ? CMD_WR : CMD_RD;
              state_d = IDLE;
            end
          end else if (ras_ok) begin
            issue = CMD_PRE;
          end
        end else if (rp_ok && rrd_ok) begin
          issue = CMD_ACT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address field of the chosen command.
  always_comb begin
    addr_d = '0;
    case (issue)
      CMD_ACT:        addr_d = lat_row;
      CMD_RD, CMD_WR: addr_d = ROW_W'(lat_col);
      default:        addr_d = '0;
    endcase
  end

  // FSM state, the request latch and the registered command outputs.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_ready <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_bg    <= '0;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
      lat_write <= 1'b0;
      lat_bg    <= '0;
      lat_ba    <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == IDLE);
      if (accept) begin
        lat_write <= req_write;
        lat_bg    <= req_bg;
        lat_ba    <= req_ba;
        lat_row   <= req_row;
        lat_col   <= req_col;
      end
      cmd_valid <= (issue != CMD_NOP);
      cmd_type  <= issue;
      cmd_bg    <= (issue != CMD_NOP) ? lat_bg : '0;
      cmd_ba    <= (issue != CMD_NOP) ? lat_ba : '0;
      cmd_addr  <= addr_d;
    end
  end

  // Per-bank open-row tracking and timing counters. Reset leaves every
  // counter saturated, so no constraint holds off the first commands.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_open[i] <= 1'b0;
        bank_row[i]  <= '0;
        since_act[i] <= CNT_MAX;
        since_pre[i] <= CNT_MAX;
      end
      last_act_cnt <= CNT_MAX;
      last_cas_cnt <= CNT_MAX;
      last_act_bg  <= '0;
      last_cas_bg  <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        since_act[i] <= sat_inc(since_act[i]);
        since_pre[i] <= sat_inc(since_pre[i]);
        if (IDX_W'(i) == idx) begin
          if (issue == CMD_ACT) begin
            bank_open[i] <= 1'b1;
            bank_row[i]  <= lat_row;
            since_act[i] <= CNT_W'(1);
          end else if (issue == CMD_PRE) begin
            bank_open[i] <= 1'b0;
            since_pre[i] <= CNT_W'(1);
          end
        end
      end
      last_act_cnt <= sat_inc(last_act_cnt);
      last_cas_cnt <= sat_inc(last_cas_cnt);
      if (issue == CMD_ACT) begin
        last_act_cnt <= CNT_W'(1);
        last_act_bg  <= lat_bg;
      end
      if (issue == CMD_RD || issue == CMD_WR) begin
        last_cas_cnt <= CNT_W'(1);
        last_cas_bg  <= lat_bg;
      end
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// tb_ddr4_cmd_scheduler
//   Self-checking bench for ddr4_cmd_scheduler. A table of directed requests
//   carries hand-computed command offsets. A reset is applied in the middle of
//   a tRCD wait. Random requests are then checked against a timestamp model
//   of the DDR4 timing rules.
module tb_ddr4_cmd_scheduler;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4;
  localparam int T_RCD = 16, T_RP = 16, T_RAS = 39;
  localparam int T_RRD_S = 4, T_RRD_L = 6, T_CCD_S = 4, T_CCD_L = 6;

  logic        clock_t = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_bg, req_ba;
  logic [16:0] req_row;
  logic [9:0]  req_col;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [16:0] cmd_addr;

  ddr4_cmd_scheduler dut (
    .clock_t  (clock_t),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_bg   (req_bg),
    .req_ba   (req_ba),
    .req_row  (req_row),
    .req_col  (req_col),
    .cmd_valid(cmd_valid),
    .cmd_type (cmd_type),
    .cmd_bg   (cmd_bg),
    .cmd_ba   (cmd_ba),
    .cmd_addr (cmd_addr)
  );

  always #5 clock_t = ~clock_t;

  // Number of the most recent rising edge; stable when read at a falling edge.
  int edge_no = 0;
  always @(posedge clock_t) edge_no <= edge_no + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected commands of the request under test (offsets already absolute).
  int          exp_n;
  int          exp_edge [3];
  logic [2:0]  exp_type [3];
  logic [1:0]  exp_bg, exp_ba;
  logic [16:0] exp_row;
  logic [9:0]  exp_col;

  typedef struct {
    logic        wr;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [16:0] row;
    logic [9:0]  col;
    int          n;
    logic [2:0]  ty0, ty1, ty2;
    int          of0, of1, of2;
  } vec_t;

  vec_t vecs [8];

  // Reference model: bank state plus absolute edge times of past commands.
  logic        m_open  [16];
  logic [16:0] m_row   [16];
  int          m_act_t [16];
  int          m_pre_t [16];
  int          m_lact_t, m_lcas_t;
  logic [1:0]  m_lact_bg, m_lcas_bg;

  task automatic compareValue(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, got, want, edge_no);
    end
  endtask

  task automatic setVec(input int i, input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [16:0] row, input logic [9:0] col, input int n,
                        input logic [2:0] t0, input logic [2:0] t1, input logic [2:0] t2,
                        input int o0, input int o1, input int o2);
    vecs[i].wr = wr;  vecs[i].bg = bg;   vecs[i].ba = ba;
    vecs[i].row = row; vecs[i].col = col; vecs[i].n = n;
    vecs[i].ty0 = t0; vecs[i].ty1 = t1; vecs[i].ty2 = t2;
    vecs[i].of0 = o0; vecs[i].of1 = o1; vecs[i].of2 = o2;
  endtask

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  task automatic modelInit();
    for (int i = 0; i < 16; i++) begin
      m_open[i]  = 1'b0;
      m_row[i]   = '0;
      m_act_t[i] = -10000;
      m_pre_t[i] = -10000;
    end
    m_lact_t = -10000; m_lcas_t = -10000;
    m_lact_bg = '0;    m_lcas_bg = '0;
  endtask

  // Predict the command edges of a request accepted at edge k.
  task automatic modelRequest(input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                              input logic [16:0] row, input logic [9:0] col, input int k);
    int b, t, x;
    b = {28'd0, bg, ba};
    t = k + 1;
    exp_n = 0; exp_bg = bg; exp_ba = ba; exp_row = row; exp_col = col;
    if (m_open[b] && m_row[b] != row) begin
      x = max3(t, m_act_t[b] + T_RAS, t);
      exp_edge[exp_n] = x; exp_type[exp_n] = PRE; exp_n++;
      m_open[b] = 1'b0; m_pre_t[b] = x; t = x + 1;
    end
    if (!m_open[b]) begin
      x = max3(t, m_pre_t[b] + T_RP, m_lact_t + ((bg == m_lact_bg) ? T_RRD_L : T_RRD_S));
      exp_edge[exp_n] = x; exp_type[exp_n] = ACT; exp_n++;
      m_open[b] = 1'b1; m_row[b] = row; m_act_t[b] = x;
      m_lact_t = x; m_lact_bg = bg; t = x + 1;
    end
    x = max3(t, m_act_t[b] + T_RCD, m_lcas_t + ((bg == m_lcas_bg) ? T_CCD_L : T_CCD_S));
    exp_edge[exp_n] = x; exp_type[exp_n] = wr ? WR : RD; exp_n++;
    m_lcas_t = x; m_lcas_bg = bg;
  endtask

  // Present a request (called in the low clock phase); k returns the accept edge.
  task automatic applyStimulus(input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                               input logic [16:0] row, input logic [9:0] col, output int k);
    int g;
    req_write = wr; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 300) begin
      @(negedge clock_t);
      g++;
    end
    if (!req_ready) compareValue("accept_timeout", 32'd0, 32'd1);
    k = edge_no + 1;
    @(posedge clock_t);
    #1;
    req_valid = 1'b0;
  endtask

  // Walk every cycle from the accept edge to the final CAS edge.
  task automatic checkOutput(input string name, input int k);
    int last, e, f;
    logic [16:0] a;
    bit done;
    last = exp_edge[exp_n-1];
    done = 1'b0;
    for (int g = 0; g < 300 && !done; g++) begin
      @(negedge clock_t);
      e = edge_no;
      f = -1;
      for (int j = 0; j < exp_n; j++) if (exp_edge[j] == e) f = j;
      if (f >= 0) begin
        if (exp_type[f] == ACT)      a = exp_row;
        else if (exp_type[f] == PRE) a = '0;
        else                         a = {7'd0, exp_col};
        compareValue($sformatf("%s cmd@+%0d", name, e - k),
                     32'({cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr}),
                     32'({1'b1, exp_type[f], exp_bg, exp_ba, a}));
      end else begin
        compareValue($sformatf("%s nop@+%0d", name, e - k),
                     32'({cmd_valid, cmd_type, cmd_addr}), 32'd0);
      end
      compareValue($sformatf("%s ready@+%0d", name, e - k), 32'(req_ready), 32'(e == last));
      if (e >= last) done = 1'b1;
    end
    if (!done) compareValue($sformatf("%s cas_timeout", name), 32'd0, 32'd1);
  endtask

  task automatic doReset();
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    compareValue("reset_cmd", 32'({cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr}), 32'd0);
    compareValue("reset_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clock_t);
    reset_n = 1'b1;
    @(negedge clock_t);
    compareValue("ready_after_reset", 32'(req_ready), 32'd1);
    modelInit();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at edge %0d", edge_no);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    logic wr;
    logic [1:0] bg, ba;
    logic [16:0] row;
    logic [9:0] col;

    req_valid = 1'b0; req_write = 1'b0; req_bg = '0; req_ba = '0;
    req_row = '0; req_col = '0; reset_n = 1'b0;
    @(negedge clock_t);
    doReset();

    // Directed table: offsets are edges after the accept edge.
    setVec(0, 1'b0, 2'd0, 2'd0, 17'd5, 10'd8,  2, ACT, RD,  NOP, 1, 17, 0);
    setVec(1, 1'b0, 2'd0, 2'd0, 17'd5, 10'd16, 1, RD,  NOP, NOP, 5, 0,  0);
    setVec(2, 1'b0, 2'd1, 2'd0, 17'd5, 10'd3,  2, ACT, RD,  NOP, 1, 17, 0);
    setVec(3, 1'b0, 2'd0, 2'd0, 17'd5, 10'd24, 1, RD,  NOP, NOP, 3, 0,  0);
    setVec(4, 1'b1, 2'd1, 2'd0, 17'd5, 10'd40, 1, WR,  NOP, NOP, 3, 0,  0);
    setVec(5, 1'b0, 2'd0, 2'd0, 17'd9, 10'd1,  3, PRE, ACT, RD,  1, 17, 33);
    setVec(6, 1'b0, 2'd2, 2'd1, 17'd3, 10'd5,  2, ACT, RD,  NOP, 1, 17, 0);
    setVec(7, 1'b1, 2'd2, 2'd1, 17'd4, 10'd6,  3, PRE, ACT, WR,  22, 38, 54);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].bg, vecs[i].ba, vecs[i].row, vecs[i].col, k);
      exp_n = vecs[i].n; exp_bg = vecs[i].bg; exp_ba = vecs[i].ba;
      exp_row = vecs[i].row; exp_col = vecs[i].col;
      exp_type[0] = vecs[i].ty0; exp_type[1] = vecs[i].ty1; exp_type[2] = vecs[i].ty2;
      exp_edge[0] = k + vecs[i].of0; exp_edge[1] = k + vecs[i].of1; exp_edge[2] = k + vecs[i].of2;
      checkOutput($sformatf("vec%0d", i), k);
    end

    // Reset while waiting out tRCD: the bank must come back closed.
    applyStimulus(1'b0, 2'd3, 2'd2, 17'd7, 10'd2, k);
    while (edge_no < k + 1) @(negedge clock_t);
    compareValue("midreset act", 32'({cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr}),
                 32'({1'b1, ACT, 2'd3, 2'd2, 17'd7}));
    while (edge_no < k + 5) @(negedge clock_t);
    reset_n = 1'b0;
    #1;
    compareValue("midreset outputs", 32'({cmd_valid, cmd_type, req_ready}), 32'd0);
    repeat (2) @(negedge clock_t);
    reset_n = 1'b1;
    @(negedge clock_t);
    applyStimulus(1'b0, 2'd3, 2'd2, 17'd7, 10'd2, k);
    exp_n = 2; exp_bg = 2'd3; exp_ba = 2'd2; exp_row = 17'd7; exp_col = 10'd2;
    exp_type[0] = ACT; exp_type[1] = RD;
    exp_edge[0] = k + 1; exp_edge[1] = k + 17;
    checkOutput("after_midreset", k);

    // Random traffic over a few rows so hits, misses and closed banks all occur.
    doReset();
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom_range(0, 1));
      bg  = 2'($urandom_range(0, 3));
      ba  = 2'($urandom_range(0, 1));
      row = 17'($urandom_range(0, 2));
      col = 10'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 3)) @(negedge clock_t);
      applyStimulus(wr, bg, ba, row, col, k);
      modelRequest(wr, bg, ba, row, col, k);
      checkOutput($sformatf("rnd%0d", i), k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
